// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : AXI-stream fed UART transmitter with a byte FIFO, optional
//            parity, 1 or 2 stop bits and fractional (1/10 cycle) baud timing.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int    CLK_FREQ  = 50000000,
  parameter int    BAUD_RATE = 115200,
  parameter string PARITY    = "NONE",
  parameter int    STOP_BITS = 1,
  parameter int    FIFO_EA   = 4
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       i_tvalid,
  output logic       i_tready,
  input  logic [7:0] i_tdata,
  output logic       o_uart_tx,
  output logic       o_busy
);

  // Divide ratio in tenths of a clock cycle, rounded to nearest.
  localparam longint DIV_X10     = (longint'(CLK_FREQ) * 20 + longint'(BAUD_RATE)) /
                                   (longint'(BAUD_RATE) * 2);
  localparam int     BAUD_CYCLES = int'(DIV_X10 / 10);
  localparam int     FRAC        = int'(DIV_X10 % 10);
  localparam longint ACTUAL_BAUD = (longint'(CLK_FREQ) * 10) / DIV_X10;
  localparam longint BAUD_DIFF   = longint'(CLK_FREQ) * 10 - longint'(BAUD_RATE) * DIV_X10;
  localparam longint BAUD_ERR    = (BAUD_DIFF < 0) ? -BAUD_DIFF : BAUD_DIFF;
  localparam bit     PAR_EN      = (PARITY == "ODD") || (PARITY == "EVEN");
  localparam bit     PAR_ODD     = (PARITY == "ODD");
  localparam int     CNT_W       = $clog2(BAUD_CYCLES + 2);
  localparam int     DEPTH       = 2 ** FIFO_EA;

  // Elaboration-time sanity checks on the configuration.
  if (BAUD_CYCLES < 32) begin : g_chk_baud_cycles
    $error("uart_tx: BAUD_CYCLES=%0d is below 32", BAUD_CYCLES);
  end
  if (BAUD_ERR * 1000 > longint'(BAUD_RATE) * DIV_X10 * 3) begin : g_chk_baud_err
    $error("uart_tx: baud error exceeds 0.3%% (actual %0d Hz)", ACTUAL_BAUD);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
    $error("uart_tx: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (!PAR_EN && PARITY != "NONE") begin : g_chk_parity
    $error("uart_tx: PARITY must be NONE, ODD or EVEN");
  end
  if (1) begin : g_baud_info
    $info("uart_tx: actual baud rate %0d Hz", ACTUAL_BAUD);
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_EA:0] r_wptr;
  logic [FIFO_EA:0] r_rptr;
  logic [FIFO_EA:0] w_wptr_nxt;
  logic [FIFO_EA:0] w_rptr_nxt;
  logic             r_tready;
  logic             r_tx;
  logic             r_busy;

  logic [7:0]       r_shift;
  logic             r_par;
  logic [2:0]       r_bitn;
  logic             r_stopn;
  logic [3:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_empty_nxt;
  logic             w_full_nxt;
  logic             w_line;
  logic             w_long;
  logic             w_bit_done;
  logic [4:0]       w_acc_sum;
  logic [CNT_W-1:0] w_bit_last;
  logic [7:0]       w_head;

  assign w_push      = i_tvalid & r_tready;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_wptr_nxt  = r_wptr + {{FIFO_EA{1'b0}}, w_push};
  assign w_rptr_nxt  = r_rptr + {{FIFO_EA{1'b0}}, w_pop};
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[FIFO_EA] != w_rptr_nxt[FIFO_EA]) &&
                       (w_wptr_nxt[FIFO_EA-1:0] == w_rptr_nxt[FIFO_EA-1:0]);
  assign w_head      = r_mem[r_rptr[FIFO_EA-1:0]];

  // A bit gets one extra cycle whenever the tenth-cycle remainder carries.
  assign w_acc_sum   = {1'b0, r_acc} + 5'(FRAC);
  assign w_long      = (w_acc_sum >= 5'd10);
  assign w_bit_last  = CNT_W'(BAUD_CYCLES - 1) + CNT_W'(w_long);
  assign w_bit_done  = (r_cnt == w_bit_last);

  assign i_tready    = r_tready;
  assign o_uart_tx   = r_tx;
  assign o_busy      = r_busy;

  // FIFO storage: written on every accepted handshake, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_EA-1:0]] <= i_tdata;
    end
  end

  // FIFO pointers, registered ready, line and busy outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_tready <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_tready <= !w_full_nxt;
      r_tx     <= w_line;
      r_busy   <= w_push | !w_empty_nxt | (r_state != S_IDLE) | (w_state_nxt != S_IDLE);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, FIFO pop and line level; a new frame may start straight
  // out of the last stop bit so queued bytes leave with no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_done && r_bitn == 3'd7) w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_line = r_par;
        if (w_bit_done) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done && r_stopn == 1'(STOP_BITS - 1)) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, fractional accumulator and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_par   <= 1'b0;
      r_bitn  <= '0;
      r_stopn <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_shift <= w_head;
      r_par   <= (^w_head) ^ PAR_ODD;
      r_bitn  <= '0;
      r_stopn <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_done) begin
        r_cnt <= '0;
        r_acc <= w_long ? 4'(w_acc_sum - 5'd10) : w_acc_sum[3:0];
        if (r_state == S_DATA) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bitn  <= r_bitn + 3'd1;
        end
        if (r_state == S_STOP) begin
          r_stopn <= r_stopn + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (10 MHz / 115200, even parity,
//            2 stop bits, 4-entry FIFO) against a frame-level line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CLK_FREQ  = 10000000;
  localparam int BAUD_RATE = 115200;
  localparam int STOP_BITS = 2;
  localparam int FIFO_EA   = 2;
  localparam int PAR_EN    = 1;
  localparam int PAR_ODD   = 0;
  localparam int D         = (CLK_FREQ * 20 + BAUD_RATE) / (BAUD_RATE * 2);
  localparam int NBITS     = 1 + 8 + PAR_EN + STOP_BITS;
  localparam int FRAME     = (NBITS * D) / 10;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_tvalid;
  logic       i_tready;
  logic [7:0] i_tdata;
  logic       o_uart_tx;
  logic       o_busy;

  int vectors;
  int miscompares;

  logic exp_v [$];
  int   exp_l [$];
  logic got_tx [$];
  logic got_busy [$];

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .PARITY   ("EVEN"),
    .STOP_BITS(STOP_BITS),
    .FIFO_EA  (FIFO_EA)
  ) u_dut (
    .rstn     (rstn),
    .clk      (clk),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .i_tdata  (i_tdata),
    .o_uart_tx(o_uart_tx),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  // Reference: level and length of every bit of one frame. Bit k ends at
  // floor((k+1)*D/10) cycles after the start edge.
  task automatic model_frame(input logic [7:0] b);
    for (int k = 0; k < NBITS; k++) begin
      logic v;
      if (k == 0)                      v = 1'b0;
      else if (k <= 8)                 v = b[k-1];
      else if (PAR_EN != 0 && k == 9)  v = (^b) ^ (PAR_ODD != 0);
      else                             v = 1'b1;
      exp_v.push_back(v);
      exp_l.push_back(((k + 1) * D) / 10 - (k * D) / 10);
    end
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      got_tx.push_back(o_uart_tx);
      got_busy.push_back(o_busy);
    end
  endtask

  task automatic clear_queues();
    exp_v.delete();
    exp_l.delete();
    got_tx.delete();
    got_busy.delete();
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_line: got %b want 1", o_uart_tx); end
    vectors++;
    if (i_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b want 0", i_tready); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (i_tready !== 1'b1) begin miscompares++; $display("FAIL release_tready: got %b want 1", i_tready); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL release_busy: got %b want 0", o_busy); end
    vectors++;
    if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL release_line: got %b want 1", o_uart_tx); end
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    int pos;
    int m;
    clear_queues();
    model_frame(b);
    @(negedge clk);
    i_tvalid = 1'b1;
    i_tdata  = b;
    vectors++;
    if (i_tready !== 1'b1) begin miscompares++; $display("FAIL %s tready: got %b want 1", name, i_tready); end
    @(posedge clk);
    @(negedge clk);
    i_tvalid = 1'b0;
    vectors++;
    if (o_busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_after_accept: got %b want 1", name, o_busy); end
    vectors++;
    if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL %s pre_start_1: got %b want 1", name, o_uart_tx); end
    @(negedge clk);
    vectors++;
    if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL %s pre_start_2: got %b want 1", name, o_uart_tx); end
    capture(FRAME + 1);
    pos = 0;
    for (int i = 0; i < exp_v.size(); i++) begin
      m = 0;
      for (int c = 0; c < exp_l[i]; c++) begin
        if (got_tx[pos] === exp_v[i]) m++;
        pos++;
      end
      vectors++;
      if (m !== exp_l[i]) begin
        miscompares++;
        $display("FAIL %s bit%0d: %0d cycles at level %0b, want %0d", name, i, m, exp_v[i], exp_l[i]);
      end
    end
    m = 0;
    for (int c = 0; c < FRAME; c++) if (got_busy[c] === 1'b1) m++;
    vectors++;
    if (m !== FRAME) begin miscompares++; $display("FAIL %s busy_in_frame: %0d cycles high, want %0d", name, m, FRAME); end
    vectors++;
    if (got_tx[FRAME] !== 1'b1) begin miscompares++; $display("FAIL %s idle_line: got %b want 1", name, got_tx[FRAME]); end
    vectors++;
    if (got_busy[FRAME] !== 1'b0) begin miscompares++; $display("FAIL %s busy_after: got %b want 0", name, got_busy[FRAME]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [8];
    int   k;
    int   first_low;
    int   guard;
    int   pos;
    int   m;
    logic rdy;
    clear_queues();
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    exp_v.push_back(1'b1);
    exp_l.push_back(2);
    for (int i = 0; i < 8; i++) model_frame(d[i]);
    @(negedge clk);
    i_tvalid = 1'b1;
    i_tdata  = d[0];
    vectors++;
    if (i_tready !== 1'b1) begin miscompares++; $display("FAIL b2b tready0: got %b want 1", i_tready); end
    @(posedge clk);
    k         = 1;
    first_low = -1;
    guard     = 0;
    fork
      begin
        while (k < 8 && guard < 20000) begin
          @(negedge clk);
          i_tdata  = d[k];
          i_tvalid = 1'b1;
          rdy      = i_tready;
          if (rdy !== 1'b1 && first_low < 0) first_low = k;
          @(posedge clk);
          if (rdy === 1'b1) k++;
          guard++;
        end
        @(negedge clk);
        i_tvalid = 1'b0;
      end
      capture(2 + 8 * FRAME + 1);
    join
    vectors++;
    if (k !== 8) begin miscompares++; $display("FAIL b2b accepted: got %0d want 8", k); end
    vectors++;
    if (first_low !== 5) begin miscompares++; $display("FAIL b2b accepts_before_full: got %0d want 5", first_low); end
    pos = 0;
    for (int i = 0; i < exp_v.size(); i++) begin
      m = 0;
      for (int c = 0; c < exp_l[i]; c++) begin
        if (got_tx[pos] === exp_v[i]) m++;
        pos++;
      end
      vectors++;
      if (m !== exp_l[i]) begin
        miscompares++;
        $display("FAIL b2b seg%0d: %0d cycles at level %0b, want %0d", i, m, exp_v[i], exp_l[i]);
      end
    end
    m = 0;
    for (int c = 0; c < pos; c++) if (got_busy[c] === 1'b1) m++;
    vectors++;
    if (m !== pos) begin miscompares++; $display("FAIL b2b busy_in_frames: %0d cycles high, want %0d", m, pos); end
    vectors++;
    if (got_tx[pos] !== 1'b1) begin miscompares++; $display("FAIL b2b idle_line: got %b want 1", got_tx[pos]); end
    vectors++;
    if (got_busy[pos] !== 1'b0) begin miscompares++; $display("FAIL b2b busy_after: got %b want 0", got_busy[pos]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q [4];
    int bad_line;
    int bad_busy;
    q[0] = 8'hA5;
    for (int i = 1; i < 4; i++) q[i] = 8'($urandom);
    @(negedge clk);
    i_tvalid = 1'b1;
    i_tdata  = q[0];
    vectors++;
    if (i_tready !== 1'b1) begin miscompares++; $display("FAIL midrst tready0: got %b want 1", i_tready); end
    @(posedge clk);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      i_tdata = q[i];
      vectors++;
      if (i_tready !== 1'b1) begin miscompares++; $display("FAIL midrst tready%0d: got %b want 1", i, i_tready); end
      @(posedge clk);
    end
    @(negedge clk);
    i_tvalid = 1'b0;
    // Now at frame cycle 1; move to cycle 390, inside data bit 3.
    repeat (389) @(negedge clk);
    vectors++;
    if (o_uart_tx !== q[0][3]) begin miscompares++; $display("FAIL midrst data_bit3: got %b want %b", o_uart_tx, q[0][3]); end
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if (o_uart_tx !== 1'b1) begin miscompares++; $display("FAIL midrst async_line: got %b want 1", o_uart_tx); end
    vectors++;
    if (i_tready !== 1'b0) begin miscompares++; $display("FAIL midrst tready_in_reset: got %b want 0", i_tready); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy_in_reset: got %b want 0", o_busy); end
    repeat (3) @(negedge clk);
    rstn     = 1'b1;
    bad_line = 0;
    bad_busy = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) bad_line++;
      if (o_busy !== 1'b0) bad_busy++;
    end
    vectors++;
    if (bad_line !== 0) begin miscompares++; $display("FAIL midrst line_after: %0d cycles not idle, want 0", bad_line); end
    vectors++;
    if (bad_busy !== 0) begin miscompares++; $display("FAIL midrst busy_after: %0d cycles busy, want 0", bad_busy); end
    vectors++;
    if (i_tready !== 1'b1) begin miscompares++; $display("FAIL midrst tready_after: got %b want 1", i_tready); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    i_tvalid    = 1'b0;
    i_tdata     = 8'h00;
    test_reset();
    test_single(8'h55, "single_55");
    test_single(8'h07, "parity_07");
    test_single(8'h00, "single_00");
    test_single(8'($urandom), "single_rand");
    test_back_to_back();
    test_reset_mid_frame();
    test_single(8'($urandom), "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: accepts bytes on an AXI-stream slave (with TREADY), buffers them in a small FIFO, and serialises each one onto a UART line. Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits. Baud timing supports a fractional divide ratio with tenth-of-a-cycle resolution. Pairs with the existing UART receiver in host-link designs (e.g. streaming compressed output back to a PC).

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in Hz
PARITY, "NONE", "NONE", "ODD" or "EVEN"
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_EA, 4, FIFO address width; depth = 2**FIFO_EA bytes

Ports:
rstn  input  1  asynchronous active-low reset
clk  input  1  clock; all logic on posedge
i_tvalid  input  1  AXI-stream slave valid
i_tready  output  1  AXI-stream slave ready; high when FIFO not full
i_tdata  input  8  byte to send
o_uart_tx  output  1  UART TX line, idle high
o_busy  output  1  high while a frame is on the line or FIFO not empty

Behaviour:
- One clock; reset is asynchronous and active-low (rstn, clk).
- Reset values: o_uart_tx=1, i_tready=0 during reset then 1 on the first clk after release, o_busy=0, FIFO empty, FSM in S_IDLE, fraction accumulator 0.
- Divide ratio: D = (CLK_FREQ*20 + BAUD_RATE) / (BAUD_RATE*2) (integer). BAUD_CYCLES = D/10, FRAC = D%10.
- Per-bit length: accumulator acc (0..9) cleared at each start bit. For every bit including start: t = acc+FRAC; if t>=10, the bit lasts BAUD_CYCLES+1 cycles and acc=t-10; otherwise it lasts BAUD_CYCLES cycles and acc=t.
- Handshake: a byte is written when i_tvalid && i_tready on a posedge. i_tready = !full (registered). No byte is dropped or duplicated. Simultaneous write and FSM pop with a full FIFO: the write is refused, because i_tready is low.
- FSM: S_IDLE -> S_START when FIFO non-empty (pop byte, load shift register). S_START: line 0 for one bit. S_DATA: 8 bits, LSB first. S_PARITY (only if PARITY != "NONE"): EVEN -> ^byte, ODD -> ~^byte. S_STOP: line 1 for STOP_BITS bits. Then S_IDLE.
- Timing: o_uart_tx is a register. The start bit begins exactly 2 cycles after the accepting handshake edge when idle (1 cycle pop, 1 cycle output register). Back-to-back bytes: the next start bit follows the last stop bit with no idle gap.
- o_busy: registered. High from the cycle after the first write until the last stop-bit cycle of the final frame completes with the FIFO empty.
- Reset mid-frame: the line returns to 1 asynchronously, the FIFO is flushed, and no partial frame resumes.
- Parameter checks at elaboration: BAUD_CYCLES < 32 -> $error. Relative baud error > 0.3% -> $error. STOP_BITS not 1 or 2 -> $error. PARITY not one of the three legal strings -> $error. Print the actual baud rate.

Test Plan:
1. 50 MHz/115200, NONE, 1 stop; send 0x55 -> line samples 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles, total 4340 cycles; o_busy low afterwards.
2. 10 MHz/115200 (D=868, FRAC=8), send 0x00 -> bit lengths 86,87,87,87,87,86,87,87,87,87 cycles, frame total 868.
3. PARITY="EVEN", send 0x07 -> parity bit 1. PARITY="ODD", send 0x07 -> parity bit 0. Frame is 11 bits.
4. FIFO_EA=2, hold i_tvalid with bytes 0x01..0x08 back-to-back -> i_tready drops after 5 accepts (4 in FIFO + 1 in flight). All 8 bytes appear in order with no inter-frame idle gap.
5. STOP_BITS=2, two queued bytes -> stop interval is 2 bit-times of 1 between frames.
6. Assert rstn low mid data bit 3 of 0xA5 with 3 bytes queued -> line goes 1 immediately. After release the line stays 1 and o_busy stays 0, since the FIFO is flushed.
